// File: rtl/w1_hash_buffer.sv
// Buffers packed w1 words from the decompose encoder and feeds them to the
// challenge-hash absorb port through a small first-word-fall-through FIFO.
module w1_hash_buffer #(
  parameter int DEPTH          = 8,
  parameter int WORDS_PER_POLY = 16,
  parameter int NUM_POLY       = 8,
  parameter int DATA_W         = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              zeroize,
  input  logic              start,
  input  logic [DATA_W-1:0] w1_i,
  input  logic              buffer_en,
  input  logic              hash_ready,
  output logic [DATA_W-1:0] hash_data,
  output logic              hash_valid,
  output logic              hash_last,
  output logic              buffer_full,
  output logic              overflow_err,
  output logic              done
);

  localparam int TOTAL = NUM_POLY * WORDS_PER_POLY;
  localparam int CNT_W = $clog2(TOTAL) + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  mem_last;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  word_cnt;
  logic              err_q;

  logic empty, full, pop, push_req, push_ok, stray, last_word, arm, head_last;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop       = !empty && hash_ready;
  assign push_req  = buffer_en && (state == FILL);
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign stray     = buffer_en && (state != FILL);
  assign last_word = push_req && (word_cnt == LAST_IDX);
  assign arm       = start && (state == IDLE);
  assign head_last = !empty && mem_last[rd_ptr[AW-1:0]];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (last_word) state_nxt = DRAIN;
      DRAIN:   if (pop && head_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (zeroize) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter advances on dropped words too, so the last tag stays on word TOTAL-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      err_q    <= 1'b0;
    end else if (zeroize) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      err_q    <= 1'b0;
    end else if (arm) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push_ok)  wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr   <= rd_ptr + PTR_W'(1);
      if (push_req) word_cnt <= word_cnt + CNT_W'(1);
      if ((push_req && !push_ok) || stray) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_data[i] <= '0;
      mem_last <= '0;
    end else if (zeroize) begin
      for (int i = 0; i < DEPTH; i++) mem_data[i] <= '0;
      mem_last <= '0;
    end else if (push_ok) begin
      mem_data[wr_ptr[AW-1:0]] <= w1_i;
      mem_last[wr_ptr[AW-1:0]] <= last_word;
    end
  end

  assign hash_valid   = !empty;
  assign hash_data    = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign hash_last    = head_last;
  assign buffer_full  = full;
  assign overflow_err = err_q;
  assign done         = (state == DONE);

endmodule

// File: tb/tb_w1_hash_buffer.sv
// Bench for w1_hash_buffer: cycle table for full/backpressure/stray cases,
// directed sequences for streaming, wrap, zeroize and async reset.
module tb_w1_hash_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n, zeroize, start, buffer_en, hash_ready;
  logic [63:0] w1_i;
  logic [63:0] hash_data;
  logic        hash_valid, hash_last, buffer_full, overflow_err, done;

  w1_hash_buffer #(.DEPTH(DEPTH), .WORDS_PER_POLY(16), .NUM_POLY(8), .DATA_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start(start), .w1_i(w1_i),
    .buffer_en(buffer_en), .hash_ready(hash_ready), .hash_data(hash_data),
    .hash_valid(hash_valid), .hash_last(hash_last), .buffer_full(buffer_full),
    .overflow_err(overflow_err), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic last; } sb_t;
  typedef struct {
    logic start, zero, en; logic [63:0] w; logic rdy, acc;
    logic valid, full, err; logic [63:0] head;
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t tbl[$];
  int   n_vec = 0, n_err = 0, done_cnt = 0;
  logic prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, z, e, input logic [63:0] w, input logic r, a,
                     input logic v, f, er, input logic [63:0] h);
    vec_t t;
    t.start = s; t.zero = z; t.en = e; t.w = w; t.rdy = r; t.acc = a;
    t.valid = v; t.full = f; t.err = er; t.head = h;
    tbl.push_back(t);
  endtask

  task automatic push_word(input logic [63:0] w, input logic last);
    sb_t t;
    t.data = w; t.last = last;
    sb.push_back(t);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, hash_valid, 0);
    chk({tag, "_data"}, hash_data, 0);
    chk({tag, "_last"}, hash_last, 0);
    chk({tag, "_full"}, buffer_full, 0);
    chk({tag, "_err"}, overflow_err, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Pops are predicted here just before the edge that performs them.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_last = 1'b0;
    end else begin
      if (done || prev_last) chk("done_timing", done, prev_last);
      if (done) done_cnt++;
      prev_last = 1'b0;
      if (hash_valid && hash_ready && !zeroize) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: got %h expected no pop", hash_data);
        end else begin
          mon_e = sb.pop_front();
          chk("pop_data", hash_data, mon_e.data);
          chk("pop_last", hash_last, mon_e.last);
          prev_last = hash_last;
        end
      end
    end
  end

  initial begin
    #400000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int cnt, start_d, bound;
    reset_n = 1'b0; zeroize = 1'b0; start = 1'b0; buffer_en = 1'b0;
    hash_ready = 1'b0; w1_i = '0;

    // Table: backpressure/full, simultaneous push+pop when full, stray input in IDLE.
    add(1,0,0,0,0,0, 0,0,0,0);
    for (int k = 0; k < 8; k++) add(0,0,1,k,0,1, 1,(k==7),0,0);
    add(0,0,1,8,0,0, 1,1,1,0);
    for (int k = 0; k < 8; k++) add(0,0,0,0,1,0, (k<7),0,1,k+1);
    add(0,0,1,9,1,1, 1,0,1,9);
    add(0,0,0,0,1,0, 0,0,1,0);
    add(0,1,0,0,0,0, 0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0);
    for (int k = 0; k < 8; k++) add(0,0,1,100+k,0,1, 1,(k==7),0,100);
    add(0,0,1,108,1,1, 1,1,0,101);
    add(0,0,0,0,1,0, 1,0,0,102);
    add(0,1,0,0,0,0, 0,0,0,0);
    add(0,0,1,64'hdead,0,0, 0,0,1,0);
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0);

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Nominal stream, one word every 4th cycle.
    start = 1'b1; tick(); start = 1'b0;
    hash_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      buffer_en = 1'b1; w1_i = i;
      push_word(i, (i == 127));
      tick();
      buffer_en = 1'b0;
      chk("nom_visible", hash_valid, 1);
      chk("nom_data", hash_data, i);
      chk("nom_last", hash_last, (i == 127));
      repeat (3) tick();
    end
    chk("nom_done_count", done_cnt, 1);
    chk("nom_err", overflow_err, 0);
    chk("nom_sb_empty", sb.size(), 0);

    // Table-driven cycles.
    for (int r = 0; r < tbl.size(); r++) begin
      start = tbl[r].start; zeroize = tbl[r].zero; buffer_en = tbl[r].en;
      w1_i = tbl[r].w; hash_ready = tbl[r].rdy;
      if (tbl[r].acc) push_word(tbl[r].w, 1'b0);
      if (tbl[r].zero) sb.delete();
      tick();
      chk($sformatf("tbl%0d_valid", r), hash_valid, tbl[r].valid);
      chk($sformatf("tbl%0d_full", r), buffer_full, tbl[r].full);
      chk($sformatf("tbl%0d_err", r), overflow_err, tbl[r].err);
      if (tbl[r].valid) chk($sformatf("tbl%0d_head", r), hash_data, tbl[r].head);
    end
    start = 1'b0; zeroize = 1'b0; buffer_en = 1'b0; hash_ready = 1'b0;

    // Random backpressure, repeated ignored starts during FILL, many pointer wraps.
    start = 1'b1; tick();
    cnt = 0;
    start_d = done_cnt;
    while (cnt < 128) begin
      hash_ready = ($urandom_range(0, 1) == 1);
      buffer_en  = (sb.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      start      = (cnt == 20) || (cnt == 77) || (cnt == 126);
      if (buffer_en) begin
        w1_i = {$urandom(), 32'(cnt)};
        push_word(w1_i, (cnt == 127));
        cnt++;
      end
      tick();
    end
    buffer_en = 1'b0; start = 1'b0; hash_ready = 1'b1;
    bound = 0;
    while (done_cnt == start_d && bound < 100) begin
      tick();
      bound++;
    end
    chk("wrap_done_seen", done_cnt - start_d, 1);
    chk("wrap_sb_empty", sb.size(), 0);
    chk("wrap_err", overflow_err, 0);
    tick();

    // Zeroize after 40 pushes with 5 entries queued.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 35; i++) begin
      buffer_en = 1'b1; w1_i = 64'h1000 + i; hash_ready = 1'b1;
      push_word(w1_i, 1'b0);
      tick();
      buffer_en = 1'b0;
      tick();
    end
    hash_ready = 1'b0;
    for (int i = 35; i < 40; i++) begin
      buffer_en = 1'b1; w1_i = 64'h1000 + i;
      push_word(w1_i, 1'b0);
      tick();
    end
    buffer_en = 1'b0;
    chk("zq_count", sb.size(), 5);
    chk("zq_head", hash_data, 64'h1000 + 35);
    zeroize = 1'b1; hash_ready = 1'b1; tick(); zeroize = 1'b0; hash_ready = 1'b0;
    sb.delete();
    chk_all_zero("zeroize");
    buffer_en = 1'b1; w1_i = 64'h55; tick(); buffer_en = 1'b0;
    chk("zq_ignored_valid", hash_valid, 0);
    chk("zq_ignored_err", overflow_err, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("zq_start_clears_err", overflow_err, 0);

    // Async reset in DRAIN with 4 words still queued.
    for (int i = 0; i < 124; i++) begin
      buffer_en = 1'b1; w1_i = 64'h2000 + i; hash_ready = 1'b1;
      push_word(w1_i, 1'b0);
      tick();
      buffer_en = 1'b0;
      tick();
    end
    hash_ready = 1'b0;
    for (int i = 124; i < 128; i++) begin
      buffer_en = 1'b1; w1_i = 64'h2000 + i;
      push_word(w1_i, (i == 127));
      tick();
    end
    buffer_en = 1'b0;
    chk("drain_valid", hash_valid, 1);
    chk("drain_head", hash_data, 64'h2000 + 124);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk_all_zero("async_reset");
    tick();
    reset_n = 1'b1;
    tick();
    chk("after_reset_valid", hash_valid, 0);
    chk("after_reset_done", done_cnt - start_d, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
